// File: rtl/neuron_grid_controller_3x2_if.sv
// ---------------------------------------------------------------------------
// neuron_grid_controller_3x2_if
//
// Handshake bundle between the timestep sequencer and the 256x256 neuron
// grid datapath of one RANC core.
//
// Datapath -> controller:
//   done_axon           axon counter has reached 255
//   nb_finish_spike     neuron counter has reached 255
//   local_buffers_full  router input buffer full (emission back-pressure)
// Controller -> datapath:
//   initial_axon_num    clear the axon counter
//   inc_axon_num        advance the axon counter
//   new_neuron          load current potentials into the neuron blocks
//   process_spike       integrate the current axon
//   update_potential    write potentials back to parameter memory
//   init_neuron_num     clear the neuron counter
//   inc_neuron_num      advance the neuron counter
//   shot                emission phase active
//
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface neuron_grid_controller_3x2_if;
    logic done_axon;
    logic nb_finish_spike;
    logic local_buffers_full;
    logic initial_axon_num;
    logic inc_axon_num;
    logic new_neuron;
    logic process_spike;
    logic update_potential;
    logic init_neuron_num;
    logic inc_neuron_num;
    logic shot;

    modport master (
        input  done_axon,
        input  nb_finish_spike,
        input  local_buffers_full,
        output initial_axon_num,
        output inc_axon_num,
        output new_neuron,
        output process_spike,
        output update_potential,
        output init_neuron_num,
        output inc_neuron_num,
        output shot
    );

    modport slave (
        output done_axon,
        output nb_finish_spike,
        output local_buffers_full,
        input  initial_axon_num,
        input  inc_axon_num,
        input  new_neuron,
        input  process_spike,
        input  update_potential,
        input  init_neuron_num,
        input  inc_neuron_num,
        input  shot
    );
endinterface

// File: rtl/neuron_grid_controller_3x2.sv
// ---------------------------------------------------------------------------
// neuron_grid_controller_3x2
//
// Per-core timestep sequencer for the neuron grid datapath of the 3x2 RANC
// array. Each accepted tick runs INIT -> AXON (256 axons) -> UPDATE ->
// SHOOT (256 neurons, stalls on router back-pressure) -> DONE -> IDLE.
// Ticks arriving while the parameter loader is busy are held as a single
// pending run; ticks arriving during a run are rejected and counted.
//
// Ports:
//   clk            clock, all state changes on posedge
//   reset_n        asynchronous active-low reset
//   tick           global timestep strobe
//   param_busy     parameter loader active; blocks run start
//   dp             datapath handshake bundle (master modport)
//   busy           sequencer not in IDLE
//   run_done       one-cycle pulse at the end of a timestep
//   tick_overrun   one-cycle pulse when a tick is rejected
//   overrun_count  saturating count of rejected ticks
//   stall_error    sticky emission-stall watchdog flag
//
// Optional feature: define NGC_STALL_WATCHDOG_EN to enable the emission
// stall watchdog. Without it stall_error is tied low and SHOOT waits on
// back-pressure indefinitely.
// ---------------------------------------------------------------------------
module neuron_grid_controller_3x2 #(
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned OVR_CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tick,
    input  logic                          param_busy,
    neuron_grid_controller_3x2_if.master  dp,
    output logic                          busy,
    output logic                          run_done,
    output logic                          tick_overrun,
    output logic [OVR_CNT_W-1:0]          overrun_count,
    output logic                          stall_error
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        AXON,
        UPDATE,
        SHOOT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pending;
    logic   pending_nxt;
    logic   stall_hit;

    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (&v) ? v : v + OVR_CNT_W'(1);
    endfunction

    // State and pending-tick registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        unique case (state)
            IDLE: begin
                // Any number of ticks while the loader is busy collapse into
                // one pending run.
                if ((tick | pending) & ~param_busy) begin
                    state_nxt   = INIT;
                    pending_nxt = 1'b0;
                end else if (tick & param_busy) begin
                    pending_nxt = 1'b1;
                end
            end
            INIT:   state_nxt = AXON;
            AXON: begin
                // The done_axon cycle still integrates axon 255.
                if (dp.done_axon) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: state_nxt = SHOOT;
            SHOOT: begin
                if (dp.nb_finish_spike & ~dp.local_buffers_full) begin
                    state_nxt = DONE;
                end else if (stall_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore decode of the datapath controls; only the neuron advance also
    // looks at back-pressure so the counter holds while the router is full.
    assign dp.initial_axon_num = (state == INIT);
    assign dp.init_neuron_num  = (state == INIT);
    assign dp.new_neuron       = (state == INIT);
    assign dp.process_spike    = (state == AXON);
    assign dp.inc_axon_num     = (state == AXON) & ~dp.done_axon;
    assign dp.update_potential = (state == UPDATE);
    assign dp.shot             = (state == SHOOT);
    assign dp.inc_neuron_num   = (state == SHOOT) & ~dp.local_buffers_full
                                 & ~dp.nb_finish_spike;
    assign busy                = (state != IDLE);
    assign run_done            = (state == DONE);

    // Rejected-tick accounting; a tick in IDLE is never an overrun, even
    // while it is being held pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_overrun  <= 1'b0;
            overrun_count <= '0;
        end else begin
            tick_overrun <= tick & (state != IDLE);
            if (tick & (state != IDLE)) begin
                overrun_count <= sat_inc(overrun_count);
            end
        end
    end

`ifdef NGC_STALL_WATCHDOG_EN
    localparam logic [15:0] STALL_LIMIT_16 = 16'(STALL_LIMIT);
    localparam logic [15:0] STALL_LIMIT_M1 = 16'(STALL_LIMIT - 1);

    logic [15:0] stall_cnt;

    // Consecutive back-pressure cycles in SHOOT. The flag rises together
    // with the count reaching the limit; the FSM leaves SHOOT on the
    // following cycle through stall_hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt   <= '0;
            stall_error <= 1'b0;
        end else begin
            if ((state == SHOOT) && dp.local_buffers_full && !stall_hit) begin
                stall_cnt <= stall_cnt + 16'd1;
                if (stall_cnt == STALL_LIMIT_M1) begin
                    stall_error <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign stall_hit = (state == SHOOT) && (stall_cnt == STALL_LIMIT_16);
`else
    localparam int unsigned stall_limit_unused = STALL_LIMIT;

    assign stall_hit   = 1'b0;
    assign stall_error = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_grid_controller_3x2.sv
// ---------------------------------------------------------------------------
// tb_neuron_grid_controller_3x2
//
// Directed bench for neuron_grid_controller_3x2. A small behavioural model
// of the datapath axon/neuron counters closes the done_axon/nb_finish_spike
// loop. Each run is driven cycle by cycle from a tick table plus windows for
// local_buffers_full and param_busy; cycle 0 is the edge that samples the
// first tick.
// ---------------------------------------------------------------------------
module tb_neuron_grid_controller_3x2;
    localparam int OVR_CNT_W   = 8;
    localparam int STALL_LIMIT = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick = 1'b0;
    logic param_busy = 1'b0;
    logic full = 1'b0;
    logic busy, run_done, tick_overrun, stall_error;
    logic [OVR_CNT_W-1:0] overrun_count;
    logic [7:0] axon_cnt, neur_cnt;

    int tests = 0;
    int fails = 0;

    bit tick_at [0:1023];
    int full_lo, full_hi, pbusy_until;
    int init_cyc, init_cnt, ps_first, ps_cnt, ia_cnt, upd_cyc, shot_first, shot_cnt;
    int inc_n_cnt, done_cyc, ovr_cnt, full_shot, full_inc, busy_early, stall_first;

    neuron_grid_controller_3x2_if dp();

    neuron_grid_controller_3x2 #(
        .STALL_LIMIT (STALL_LIMIT),
        .OVR_CNT_W   (OVR_CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .param_busy    (param_busy),
        .dp            (dp),
        .busy          (busy),
        .run_done      (run_done),
        .tick_overrun  (tick_overrun),
        .overrun_count (overrun_count),
        .stall_error   (stall_error)
    );

    always #5 clk = ~clk;

    // Datapath counter model
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            axon_cnt <= 8'd0;
            neur_cnt <= 8'd0;
        end else begin
            if (dp.initial_axon_num) axon_cnt <= 8'd0;
            else if (dp.inc_axon_num) axon_cnt <= axon_cnt + 8'd1;
            if (dp.init_neuron_num) neur_cnt <= 8'd0;
            else if (dp.inc_neuron_num) neur_cnt <= neur_cnt + 8'd1;
        end
    end

    assign dp.done_axon          = (axon_cnt == 8'd255);
    assign dp.nb_finish_spike    = (neur_cnt == 8'd255);
    assign dp.local_buffers_full = full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 1024; i++) tick_at[i] = 1'b0;
        full_lo     = -1;
        full_hi     = -2;
        pbusy_until = 0;
    endtask

    task automatic do_run(input int n);
        init_cyc = -1; init_cnt = 0; ps_first = -1; ps_cnt = 0; ia_cnt = 0;
        upd_cyc = -1; shot_first = -1; shot_cnt = 0; inc_n_cnt = 0;
        done_cyc = -1; ovr_cnt = 0; full_shot = 0; full_inc = 0;
        busy_early = 0; stall_first = -1;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            tick       = tick_at[c];
            full       = (c >= full_lo) && (c <= full_hi);
            param_busy = (c < pbusy_until);
            #1;
            if (c >= 1) begin
                if (dp.new_neuron) begin
                    init_cnt++;
                    if (init_cyc < 0) init_cyc = c;
                end
                if (dp.process_spike) begin
                    ps_cnt++;
                    if (ps_first < 0) ps_first = c;
                end
                if (dp.inc_axon_num) ia_cnt++;
                if (dp.update_potential && upd_cyc < 0) upd_cyc = c;
                if (dp.shot) begin
                    shot_cnt++;
                    if (shot_first < 0) shot_first = c;
                end
                if (dp.inc_neuron_num) inc_n_cnt++;
                if (run_done && done_cyc < 0) done_cyc = c;
                if (tick_overrun) ovr_cnt++;
                if (full && dp.shot) full_shot++;
                if (full && dp.inc_neuron_num) full_inc++;
                if (busy && c <= pbusy_until) busy_early++;
                if (stall_error && stall_first < 0) stall_first = c;
            end
        end
        @(negedge clk);
        tick = 1'b0; full = 1'b0; param_busy = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_shot", dp.shot, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_run_done", run_done, 0);
        check("post_rst_ovr_count", overrun_count, 0);
        check("post_rst_stall", stall_error, 0);
        check("post_rst_init", dp.new_neuron, 0);

        // Single clean timestep
        clear_stim();
        tick_at[0] = 1'b1;
        do_run(530);
        check("t1_init_cyc", init_cyc, 1);
        check("t1_init_cnt", init_cnt, 1);
        check("t1_ps_first", ps_first, 2);
        check("t1_ps_cnt", ps_cnt, 256);
        check("t1_inc_axon_cnt", ia_cnt, 255);
        check("t1_update_cyc", upd_cyc, 258);
        check("t1_shot_first", shot_first, 259);
        check("t1_shot_cnt", shot_cnt, 256);
        check("t1_inc_neuron_cnt", inc_n_cnt, 255);
        check("t1_run_done_cyc", done_cyc, 515);
        check("t1_overrun_pulses", ovr_cnt, 0);
        check("t1_busy_after", busy, 0);

        // Ten cycles of back-pressure mid-emission
        clear_stim();
        tick_at[0] = 1'b1;
        full_lo = 300;
        full_hi = 309;
        do_run(540);
        check("t2_run_done_cyc", done_cyc, 525);
        check("t2_shot_cnt", shot_cnt, 266);
        check("t2_shot_while_full", full_shot, 10);
        check("t2_inc_while_full", full_inc, 0);
        check("t2_inc_neuron_cnt", inc_n_cnt, 255);
        check("t2_stall_error", stall_error, 0);

        // Ticks held pending during a parameter load
        clear_stim();
        tick_at[0]  = 1'b1;
        tick_at[5]  = 1'b1;
        pbusy_until = 20;
        do_run(560);
        check("t3_busy_during_load", busy_early, 0);
        check("t3_init_cyc", init_cyc, 21);
        check("t3_init_cnt", init_cnt, 1);
        check("t3_run_done_cyc", done_cyc, 535);
        check("t3_overrun_pulses", ovr_cnt, 0);
        check("t3_overrun_count", overrun_count, 0);

        // Overrun ticks in AXON and in DONE
        clear_stim();
        tick_at[0]   = 1'b1;
        tick_at[100] = 1'b1;
        tick_at[515] = 1'b1;
        do_run(530);
        check("t4_overrun_pulses", ovr_cnt, 2);
        check("t4_overrun_count", overrun_count, 2);
        check("t4_update_cyc", upd_cyc, 258);
        check("t4_run_done_cyc", done_cyc, 515);
        check("t4_init_cnt", init_cnt, 1);
        check("t4_busy_after", busy, 0);

        // Saturation of the overrun counter
        clear_stim();
        for (int i = 0; i <= 300; i++) tick_at[i] = 1'b1;
        do_run(530);
        check("t5_overrun_pulses", ovr_cnt, 300);
        check("t5_overrun_count_sat", overrun_count, 255);
        check("t5_run_done_cyc", done_cyc, 515);

`ifdef NGC_STALL_WATCHDOG_EN
        // Watchdog abort with back-pressure held from the start of SHOOT
        clear_stim();
        tick_at[0] = 1'b1;
        full_lo = 259;
        full_hi = 400;
        do_run(410);
        check("t6_stall_first", stall_first, 275);
        check("t6_run_done_cyc", done_cyc, 276);
        check("t6_stall_sticky", stall_error, 1);
        check("t6_busy_after", busy, 0);
`endif

        // Asynchronous reset in the middle of AXON
        clear_stim();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (49) @(negedge clk);
        check("t7_busy_pre_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t7_busy", busy, 0);
        check("t7_process_spike", dp.process_spike, 0);
        check("t7_inc_axon", dp.inc_axon_num, 0);
        check("t7_overrun_count", overrun_count, 0);
        check("t7_stall_error", stall_error, 0);
        check("t7_run_done", run_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_busy_after_release", busy, 0);
        check("t7_update_after_release", dp.update_potential, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
